mem_stage_ctrl: RTL and testbench

//  MEM-stage consumer of the decode control bits (mem_read, mem_write, mem_to_reg, reg_write).

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/mem_stage_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage controller: FSM states,
// default widths, alignment mask and error-cause codes.
package mem_stage_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_REG_W       = 5;
  localparam int DEF_TIMEOUT_CYC = 64;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  // Classifies a memory op at accept time; only meaningful when rd|wr.
  function automatic logic [1:0] classify_op(input logic rd, input logic wr,
                                             input logic [1:0] addr_lo);
    logic [1:0] cause;
    cause = ERR_NONE;
    if (rd && wr)
      cause = ERR_ILLEGAL;
    else if ((addr_lo & ALIGN_MASK) != 2'b00)
      cause = ERR_MISALIGN;
    return cause;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus-transaction watchdog: cleared when a transaction is accepted, counts
// while enabled and flags expiry on the TIMEOUT_CYC-th enabled cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !expire)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns one EX/MEM entry into a req/gnt + rvalid
// data-memory transaction, stalls upstream meanwhile, emits a write-back record.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  dest_reg,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  state_t            state;
  logic              lat_mem_to_reg;
  logic              lat_reg_write;
  logic [REG_W-1:0]  lat_dest;
  logic              accept;
  logic              is_mem;
  logic              expire;
  logic [1:0]        fault;
  logic [DATA_W-1:0] load_data;

  assign accept = (state == IDLE) || (state == DONE);
  assign is_mem = mem_read || mem_write;
  assign stall  = (state == REQ) || (state == WAIT_R);
  // expire can only be high while stalled, so in accept states fault is the op class.
  assign fault  = expire ? ERR_TIMEOUT : classify_op(mem_read, mem_write, alu_result[1:0]);
  // dm_addr doubles as the latched ALU result for the write-back path.
  assign load_data = lat_mem_to_reg ? dm_rdata : DATA_W'(dm_addr);

  mem_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(stall),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      dm_req         <= 1'b0;
      dm_we          <= 1'b0;
      dm_addr        <= '0;
      dm_wdata       <= '0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_dest        <= '0;
      wb_data        <= '0;
      mem_err        <= 1'b0;
      lat_mem_to_reg <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_dest       <= '0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= reg_write;
              wb_dest      <= dest_reg;
              wb_data      <= DATA_W'(alu_result);
            end else if (fault != ERR_NONE) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_dest      <= dest_reg;
              mem_err      <= 1'b1;
            end else begin
              state          <= REQ;
              dm_req         <= 1'b1;
              dm_we          <= mem_write;
              dm_addr        <= alu_result;
              dm_wdata       <= store_data;
              lat_mem_to_reg <= mem_to_reg;
              lat_reg_write  <= reg_write;
              lat_dest       <= dest_reg;
            end
          end
        end
        REQ, WAIT_R: begin
          if (fault == ERR_TIMEOUT) begin
            state        <= DONE;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_dest      <= lat_dest;
            wb_data      <= DATA_W'(dm_addr);
            mem_err      <= 1'b1;
          end else if (state == REQ && dm_gnt) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (dm_we) begin
              state        <= DONE;
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_dest      <= lat_dest;
              wb_data      <= DATA_W'(dm_addr);
            end else if (dm_rvalid) begin
              state        <= DONE;
              wb_valid     <= 1'b1;
              wb_reg_write <= lat_reg_write;
              wb_dest      <= lat_dest;
              wb_data      <= load_data;
            end else begin
              state <= WAIT_R;
            end
          end else if (state == WAIT_R && dm_rvalid) begin
            state        <= DONE;
            wb_valid     <= 1'b1;
            wb_reg_write <= lat_reg_write;
            wb_dest      <= lat_dest;
            wb_data      <= load_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU pass-through, load/store handshakes,
// misaligned/illegal ops, timeout, back-to-back accept and mid-transaction reset.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_read, mem_write, mem_to_reg, reg_write;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dest_reg;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .ADDR_W(32), .DATA_W(32), .REG_W(5), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest), .wb_data(wb_data), .mem_err(mem_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
    alu_result = 0; store_data = 0; dest_reg = 0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    step();
    total++; if ({stall, dm_req, dm_we, wb_valid, mem_err, wb_reg_write} !== 6'b0) begin
      $display("FAIL reset_ctrl got=%b want=000000", {stall, dm_req, dm_we, wb_valid, mem_err, wb_reg_write}); bad++; end
    total++; if ({dm_addr, dm_wdata, wb_data, wb_dest} !== 101'b0) begin
      $display("FAIL reset_data addr=%h wdata=%h wb_data=%h dest=%0d want all 0", dm_addr, dm_wdata, wb_data, wb_dest); bad++; end
    reset = 1;
    step();
    $display("reset: stall=%b dm_req=%b wb_valid=%b", stall, dm_req, wb_valid);
  endtask

  task automatic test_alu();
    int stall_seen = 0;
    in_valid = 1; alu_result = 32'h1234; reg_write = 1; dest_reg = 5;
    if (stall) stall_seen++;
    step();
    idle_inputs();
    if (stall) stall_seen++;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234) begin
      $display("FAIL alu_wb valid=%b data=%h want 1/00001234", wb_valid, wb_data); bad++; end
    total++; if (wb_reg_write !== 1'b1 || wb_dest !== 5'd5 || mem_err !== 1'b0) begin
      $display("FAIL alu_fields rw=%b dest=%0d err=%b want 1/5/0", wb_reg_write, wb_dest, mem_err); bad++; end
    step();
    if (stall) stall_seen++;
    total++; if (wb_valid !== 1'b0 || wb_data !== 32'h1234) begin
      $display("FAIL alu_pulse valid=%b data=%h want 0/00001234 held", wb_valid, wb_data); bad++; end
    total++; if (stall_seen !== 0) begin
      $display("FAIL alu_stall stall_cycles=%0d want 0", stall_seen); bad++; end
    $display("alu: wb_data=%h dest=%0d", wb_data, wb_dest);
  endtask

  task automatic test_load();
    int stall_cnt = 0;
    in_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; dest_reg = 7; alu_result = 32'h100;
    step();
    idle_inputs();
    total++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h100) begin
      $display("FAIL load_req req=%b we=%b addr=%h want 1/0/00000100", dm_req, dm_we, dm_addr); bad++; end
    for (int c = 1; c <= 5; c++) begin
      if (stall) stall_cnt++;
      if (c == 3) begin
        total++; if (dm_req !== 1'b0) begin
          $display("FAIL load_wait_req req=%b want 0", dm_req); bad++; end
      end
      dm_gnt    = (c == 2);
      dm_rvalid = (c == 5);
      dm_rdata  = (c == 5) ? 32'hDEADBEEF : 32'h0;
      step();
    end
    idle_inputs();
    total++; if (stall_cnt !== 5 || stall !== 1'b0) begin
      $display("FAIL load_stall cycles=%0d stall_now=%b want 5/0", stall_cnt, stall); bad++; end
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_reg_write !== 1'b1 || wb_dest !== 5'd7) begin
      $display("FAIL load_wb valid=%b data=%h rw=%b dest=%0d want 1/deadbeef/1/7", wb_valid, wb_data, wb_reg_write, wb_dest); bad++; end
    step();
    $display("load: stall_cycles=%0d wb_data=deadbeef expected", stall_cnt);
  endtask

  task automatic test_store();
    in_valid = 1; mem_write = 1; reg_write = 1; dest_reg = 3; alu_result = 32'h40; store_data = 32'hA5A5A5A5;
    step();
    idle_inputs();
    total++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 32'h40 || dm_wdata !== 32'hA5A5A5A5) begin
      $display("FAIL store_req req=%b we=%b addr=%h wdata=%h want 1/1/00000040/a5a5a5a5", dm_req, dm_we, dm_addr, dm_wdata); bad++; end
    dm_gnt = 1;
    step();
    dm_gnt = 0;
    total++; if (dm_we !== 1'b0 || dm_req !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL store_release we=%b req=%b stall=%b want 0/0/0", dm_we, dm_req, stall); bad++; end
    total++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || mem_err !== 1'b0) begin
      $display("FAIL store_wb valid=%b rw=%b err=%b want 1/0/0", wb_valid, wb_reg_write, mem_err); bad++; end
    step();
    $display("store: addr=00000040 data=a5a5a5a5 completed");
  endtask

  task automatic test_misaligned();
    in_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; dest_reg = 6; alu_result = 32'h102;
    step();
    idle_inputs();
    total++; if (dm_req !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL misalign_bus req=%b stall=%b want 0/0", dm_req, stall); bad++; end
    total++; if (wb_valid !== 1'b1 || mem_err !== 1'b1 || wb_reg_write !== 1'b0) begin
      $display("FAIL misalign_wb valid=%b err=%b rw=%b want 1/1/0", wb_valid, mem_err, wb_reg_write); bad++; end
    step();
    total++; if (mem_err !== 1'b0 || wb_valid !== 1'b0) begin
      $display("FAIL misalign_pulse err=%b valid=%b want 0/0", mem_err, wb_valid); bad++; end
    in_valid = 1; mem_read = 1; mem_write = 1; reg_write = 1; alu_result = 32'h80;
    step();
    idle_inputs();
    total++; if (dm_req !== 1'b0 || mem_err !== 1'b1 || wb_reg_write !== 1'b0) begin
      $display("FAIL illegal_rw req=%b err=%b rw=%b want 0/1/0", dm_req, mem_err, wb_reg_write); bad++; end
    step();
    $display("misaligned/illegal: rejected without bus access");
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    in_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; dest_reg = 8; alu_result = 32'h300;
    step();
    idle_inputs();
    for (int c = 0; c < 20; c++) begin
      if (!dm_req) break;
      req_cnt++;
      step();
    end
    total++; if (req_cnt !== 8) begin
      $display("FAIL timeout_len req_cycles=%0d want 8", req_cnt); bad++; end
    total++; if (mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL timeout_wb err=%b valid=%b rw=%b stall=%b want 1/1/0/0", mem_err, wb_valid, wb_reg_write, stall); bad++; end
    step();
    $display("timeout: req_cycles=%0d", req_cnt);
  endtask

  task automatic test_back_to_back();
    in_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; dest_reg = 10; alu_result = 32'h200;
    step();
    idle_inputs();
    dm_gnt = 1; dm_rvalid = 1; dm_rdata = 32'hCAFEF00D;
    step();
    idle_inputs();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D || wb_dest !== 5'd10) begin
      $display("FAIL b2b_load valid=%b data=%h dest=%0d want 1/cafef00d/10", wb_valid, wb_data, wb_dest); bad++; end
    in_valid = 1; alu_result = 32'h55; reg_write = 1; dest_reg = 2;
    step();
    idle_inputs();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_dest !== 5'd2) begin
      $display("FAIL b2b_alu valid=%b data=%h dest=%0d want 1/00000055/2", wb_valid, wb_data, wb_dest); bad++; end
    step();
    $display("back_to_back: load then alu without bubble");
  endtask

  task automatic test_reset_mid();
    in_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; dest_reg = 11; alu_result = 32'h400;
    step();
    idle_inputs();
    dm_gnt = 1;
    step();
    dm_gnt = 0;
    total++; if (stall !== 1'b1 || dm_req !== 1'b0) begin
      $display("FAIL midrst_wait stall=%b req=%b want 1/0", stall, dm_req); bad++; end
    reset = 0;
    #1;
    total++; if (dm_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
      $display("FAIL midrst_async req=%b stall=%b valid=%b want 0/0/0", dm_req, stall, wb_valid); bad++; end
    step();
    reset = 1;
    dm_rvalid = 1; dm_rdata = 32'h0BAD0BAD;
    step();
    dm_rvalid = 0;
    total++; if (wb_valid !== 1'b0 || mem_err !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL midrst_late_rvalid valid=%b err=%b stall=%b want 0/0/0", wb_valid, mem_err, stall); bad++; end
    in_valid = 1; alu_result = 32'h99; reg_write = 1; dest_reg = 4;
    step();
    idle_inputs();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h99 || wb_dest !== 5'd4 || wb_reg_write !== 1'b1) begin
      $display("FAIL midrst_alu valid=%b data=%h dest=%0d rw=%b want 1/00000099/4/1", wb_valid, wb_data, wb_dest, wb_reg_write); bad++; end
    step();
    $display("reset_mid: transaction dropped, next alu ok");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
